// File: rtl/sprite_slot_arbiter_if.sv
// Purpose: spawn-request, scroll-control and slot-table signals between requesters, arbiter and renderer.
// Latency: none, wires only.
// Backpressure: requests are held level-high until a one-cycle grant pulse comes back.
interface sprite_slot_arbiter_if #(
  parameter int SLOTS = 4
);
  logic                  step;
  logic                  over;
  logic [1:0]            req;
  logic [4:0]            req_row0;
  logic [4:0]            req_row1;
  logic [1:0]            gnt;
  logic [SLOTS*17-1:0]   slots;
  logic [3:0]            active_cnt;
  logic                  full;

  // Requester / control side
  modport master (
    output step, over, req, req_row0, req_row1,
    input  gnt, slots, active_cnt, full
  );

  // Arbiter side
  modport slave (
    input  step, over, req, req_row0, req_row1,
    output gnt, slots, active_cnt, full
  );
endinterface

// File: rtl/sprite_slot_arbiter.sv
// Purpose: shared scrolling sprite-slot table with two-requester spawn arbitration and spawn spacing.
// Latency: a request seen at an eligible edge is granted and written into the slot table at that edge.
// Backpressure: while the gap is short, the table is full or over is high, requests simply wait (no timeout).
module sprite_slot_arbiter #(
  parameter int         SLOTS     = 4,
  parameter logic [9:0] SPAWN_COL = 10'd700,
  parameter int         MIN_GAP   = 114
) (
  input  logic                 clk,
  input  logic                 rst,
  sprite_slot_arbiter_if.slave bus
);

  // One slot exactly as the renderer sees it on the packed bus.
  typedef struct packed {
    logic       en;
    logic       owner;
    logic [4:0] row;
    logic [9:0] col;
  } slot_t;

  localparam logic [7:0] GAP_MAX = 8'(MIN_GAP);
  localparam int         IDX_W   = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [3:0] CNT_MAX = 4'(SLOTS);

  slot_t            slot_q   [SLOTS];
  slot_t            slot_scr [SLOTS];
  slot_t            slot_d   [SLOTS];
  logic [SLOTS-1:0] free_vec;
  logic [IDX_W-1:0] free_idx;

  logic [7:0]       gap_q;
  logic [7:0]       gap_d;
  logic             rr_q;
  logic             rr_d;
  logic [1:0]       gnt_q;
  logic [1:0]       gnt_d;
  logic [3:0]       cnt_q;
  logic [3:0]       cnt_d;
  logic             full_q;
  logic             full_d;

  logic             eligible;
  logic             grant;
  logic             winner;
  logic [4:0]       win_row;

  // Scroll every live slot one column left on a step; a slot already at column 0 retires.
  // A free slot is one that is empty before the scroll, so a slot retired this cycle
  // cannot be reused until the next cycle.
  always_comb begin
    for (int i = 0; i < SLOTS; i++) begin
      slot_scr[i] = slot_q[i];
      free_vec[i] = ~slot_q[i].en;
      if (bus.step && slot_q[i].en) begin
        if (slot_q[i].col == 10'd0) begin
          slot_scr[i] = '0;
        end else begin
          slot_scr[i].col = slot_q[i].col - 10'd1;
        end
      end
    end
  end

  // Lowest-index free slot; scanning downward lets the lowest match win.
  always_comb begin
    free_idx = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (free_vec[i]) begin
        free_idx = IDX_W'(i);
      end
    end
  end

  // Eligibility and winner selection: a lone requester wins, otherwise the round-robin pointer decides.
  always_comb begin
    eligible = (gap_q >= GAP_MAX) && (|free_vec);
    grant    = !bus.over && eligible && (|bus.req);
    winner   = (bus.req == 2'b11) ? rr_q : bus.req[1];
    win_row  = winner ? bus.req_row1 : bus.req_row0;
  end

  // Next-state for the slot table, gap counter, round-robin pointer and grant pulse.
  // Game over freezes everything; the grant overrides the scroll for the slot it fills,
  // so a freshly spawned slot is never decremented by a coincident step.
  always_comb begin
    slot_d = slot_q;
    gap_d  = gap_q;
    rr_d   = rr_q;
    gnt_d  = '0;
    if (!bus.over) begin
      slot_d = slot_scr;
      if (grant) begin
        slot_d[free_idx].en    = 1'b1;
        slot_d[free_idx].owner = winner;
        slot_d[free_idx].row   = win_row;
        slot_d[free_idx].col   = SPAWN_COL;
        gnt_d[winner]          = 1'b1;
        rr_d                   = ~winner;
        gap_d                  = 8'd0;
      end else if (bus.step && (gap_q < GAP_MAX)) begin
        gap_d = gap_q + 8'd1;
      end
    end
  end

  // Occupancy derived from the post-edge table so active_cnt/full line up with the slots they describe.
  always_comb begin
    cnt_d = 4'd0;
    for (int i = 0; i < SLOTS; i++) begin
      cnt_d = cnt_d + {3'd0, slot_d[i].en};
    end
    full_d = (cnt_d == CNT_MAX);
  end

  // State register; reset discards every slot and any pending grant immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) begin
        slot_q[i] <= '0;
      end
      gap_q  <= 8'd0;
      rr_q   <= 1'b0;
      gnt_q  <= 2'b00;
      cnt_q  <= 4'd0;
      full_q <= 1'b0;
    end else begin
      for (int i = 0; i < SLOTS; i++) begin
        slot_q[i] <= slot_d[i];
      end
      gap_q  <= gap_d;
      rr_q   <= rr_d;
      gnt_q  <= gnt_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
    end
  end

  // Pack the table for the renderer: slot i occupies bits [17i+16:17i].
  for (genvar g = 0; g < SLOTS; g++) begin : g_pack
    assign bus.slots[17*g +: 17] = slot_q[g];
  end

  assign bus.gnt        = gnt_q;
  assign bus.active_cnt = cnt_q;
  assign bus.full       = full_q;

endmodule

// File: tb/tb_sprite_slot_arbiter.sv
// Bench for sprite_slot_arbiter: directed spawn/scroll/freeze/reset scenarios,
// a per-cycle comparison against a slot-list model, and literal pins at key points.
module tb_sprite_slot_arbiter;

  localparam int         NS   = 4;
  localparam int         GAP  = 4;
  // Spawn column leaves room for four spaced spawns before the first one retires.
  localparam logic [9:0] SC   = 10'd20;
  localparam logic [4:0] ROW0 = 5'd5;
  localparam logic [4:0] ROW1 = 5'd9;

  logic clk;
  logic rst;

  sprite_slot_arbiter_if #(.SLOTS(NS)) bus ();

  sprite_slot_arbiter #(
    .SLOTS    (NS),
    .SPAWN_COL(SC),
    .MIN_GAP  (GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // Model: a list of sprites with plain integer fields.
  int m_en  [NS];
  int m_own [NS];
  int m_row [NS];
  int m_col [NS];
  int m_gap;
  int m_rr;
  int m_gnt;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_en[i] = 0; m_own[i] = 0; m_row[i] = 0; m_col[i] = 0;
    end
    m_gap = 0;
    m_rr  = 0;
    m_gnt = 0;
  endtask

  // Apply one clock edge worth of game rules to the model.
  task automatic model_update();
    int free;
    int w;
    int pend;
    if (rst) begin
      model_reset();
      return;
    end
    if (bus.over) begin
      m_gnt = 0;
      return;
    end
    free = -1;
    for (int i = 0; i < NS; i++) begin
      if (m_en[i] == 0 && free < 0) free = i;
    end
    pend = int'(bus.req);
    if (bus.step) begin
      for (int i = 0; i < NS; i++) begin
        if (m_en[i] != 0) begin
          if (m_col[i] == 0) begin
            m_en[i] = 0; m_own[i] = 0; m_row[i] = 0;
          end else begin
            m_col[i] = m_col[i] - 1;
          end
        end
      end
    end
    if (m_gap >= GAP && free >= 0 && pend != 0) begin
      w = (pend == 3) ? m_rr : ((pend == 2) ? 1 : 0);
      m_en[free]  = 1;
      m_own[free] = w;
      m_row[free] = (w == 1) ? int'(bus.req_row1) : int'(bus.req_row0);
      m_col[free] = int'(SC);
      m_gnt = 1 << w;
      m_rr  = 1 - w;
      m_gap = 0;
    end else begin
      m_gnt = 0;
      if (bus.step && m_gap < GAP) m_gap = m_gap + 1;
    end
  endtask

  task automatic compare();
    logic [NS*17-1:0] e;
    int cnt;
    e   = '0;
    cnt = 0;
    for (int i = 0; i < NS; i++) begin
      if (m_en[i] != 0) begin
        e[17*i +: 17] = {1'b1, 1'(m_own[i]), 5'(m_row[i]), 10'(m_col[i])};
        cnt++;
      end
    end
    chk("model_slots", 128'(bus.slots), 128'(e));
    chk("model_gnt", 128'(bus.gnt), 128'(m_gnt));
    chk("model_active_cnt", 128'(bus.active_cnt), 128'(cnt));
    chk("model_full", 128'(bus.full), 128'(cnt == NS));
  endtask

  // One clock: hold inputs across the edge, advance the model, compare at the falling edge.
  task automatic cyc(input logic st);
    bus.step = st;
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
    bus.step = 1'b0;
  endtask

  function automatic logic [16:0] slot_of(input int i);
    return bus.slots[17*i +: 17];
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    model_reset();
    rst          = 1'b1;
    bus.step     = 1'b0;
    bus.over     = 1'b0;
    bus.req      = 2'b01;
    bus.req_row0 = ROW0;
    bus.req_row1 = ROW1;

    // Reset state
    cyc(1'b0);
    cyc(1'b0);
    chk("reset_slots", 128'(bus.slots), 128'd0);
    chk("reset_gnt", 128'(bus.gnt), 128'd0);
    chk("reset_cnt", 128'(bus.active_cnt), 128'd0);
    chk("reset_full", 128'(bus.full), 128'd0);
    rst = 1'b0;

    // Gap after reset: four steps needed before the first grant
    for (int k = 0; k < GAP; k++) begin
      cyc(1'b1);
      chk("gap_nognt", 128'(bus.gnt), 128'd0);
    end
    cyc(1'b0);
    chk("first_gnt", 128'(bus.gnt), 128'd1);
    chk("first_slot0", 128'(slot_of(0)), 128'({1'b1, 1'b0, ROW0, SC}));
    chk("first_cnt", 128'(bus.active_cnt), 128'd1);
    bus.req = 2'b00;

    // Scroll down to column 0, then retire with a simultaneous request
    for (int k = 0; k < int'(SC); k++) cyc(1'b1);
    chk("col_zero_slot0", 128'(slot_of(0)), 128'({1'b1, 1'b0, ROW0, 10'd0}));
    bus.req = 2'b01;
    cyc(1'b1);
    chk("retire_slot0", 128'(slot_of(0)), 128'd0);
    chk("retire_gnt", 128'(bus.gnt), 128'd1);
    chk("retire_slot1", 128'(slot_of(1)), 128'({1'b1, 1'b0, ROW0, SC}));
    chk("retire_cnt", 128'(bus.active_cnt), 128'd1);
    bus.req = 2'b11;

    // Round-robin from a fresh reset
    rst = 1'b1;
    cyc(1'b0);
    rst = 1'b0;
    for (int r = 0; r < NS; r++) begin
      for (int k = 0; k < GAP; k++) cyc(1'b1);
      cyc(1'b0);
      chk("rr_gnt", 128'(bus.gnt), 128'((r % 2 == 0) ? 2'b01 : 2'b10));
      chk("rr_owner", 128'(bus.slots[17*r + 15]), 128'(r % 2));
    end
    chk("rr_full", 128'(bus.full), 128'd1);
    chk("rr_cnt", 128'(bus.active_cnt), 128'd4);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1);
      chk("full_nognt", 128'(bus.gnt), 128'd0);
    end

    // Full then free: slot0 is at column 5
    bus.req = 2'b10;
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1);
      chk("wait_free_nognt", 128'(bus.gnt), 128'd0);
    end
    cyc(1'b1);
    chk("free_retire_gnt", 128'(bus.gnt), 128'd0);
    chk("free_retire_slot0", 128'(slot_of(0)), 128'd0);
    chk("free_retire_full", 128'(bus.full), 128'd0);
    chk("free_retire_cnt", 128'(bus.active_cnt), 128'd3);
    cyc(1'b0);
    chk("free_gnt", 128'(bus.gnt), 128'd2);
    chk("free_slot0", 128'(slot_of(0)), 128'({1'b1, 1'b1, ROW1, SC}));
    chk("free_full", 128'(bus.full), 128'd1);
    bus.req = 2'b00;

    // Game over freeze with steps and a pending request
    bus.over = 1'b1;
    bus.req  = 2'b01;
    for (int k = 0; k < 20; k++) begin
      cyc(1'(k % 2));
      chk("over_nognt", 128'(bus.gnt), 128'd0);
    end
    chk("over_slot0", 128'(slot_of(0)), 128'({1'b1, 1'b1, ROW1, SC}));
    chk("over_slot1", 128'(slot_of(1)), 128'({1'b1, 1'b1, ROW1, 10'd3}));
    bus.over = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1);
      chk("resume_nognt", 128'(bus.gnt), 128'd0);
    end
    cyc(1'b0);
    chk("resume_gnt", 128'(bus.gnt), 128'd1);
    chk("resume_slot1", 128'(slot_of(1)), 128'({1'b1, 1'b0, ROW0, SC}));

    // Asynchronous reset between edges with the table full
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("arst_slots", 128'(bus.slots), 128'd0);
    chk("arst_gnt", 128'(bus.gnt), 128'd0);
    chk("arst_cnt", 128'(bus.active_cnt), 128'd0);
    chk("arst_full", 128'(bus.full), 128'd0);
    cyc(1'b0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1);
      chk("post_arst_nognt", 128'(bus.gnt), 128'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
